// File: rtl/adc_capture.sv
// Equivalent-time sample capture: buffers one record of ADC words on jdclk strobes,
// then serves it to the MCU by read strobe. Optional ADC_CAP_AVG_EN stores pair averages.
module adc_capture #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          c0,
    input  logic          rst,
    input  logic          locked,
    input  logic          jdclk,
    input  logic [DW-1:0] adc_d,
    input  logic          start,
    input  logic          rd_stb,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   cnt,
    output logic [DW-1:0] rd_data
);

    localparam logic [AW-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

    state_t        state_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   cnt_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          err_reg;
    logic [DW-1:0] rd_data_reg;
    logic          jd_q_reg;

    logic [DW-1:0] mem [2**AW];

    // Bit 0 carries start, bit 1 carries rd_stb; both are MCU-side asynchronous
    logic [1:0] async_in;
    logic [1:0] edge_evt;
    assign async_in = {rd_stb, start};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic s1_reg, s2_reg, s3_reg;
            always_ff @(posedge c0 or negedge rst) begin
                if (!rst) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                    s3_reg <= 1'b0;
                end else begin
                    s1_reg <= async_in[gi];
                    s2_reg <= s1_reg;
                    s3_reg <= s2_reg;
                end
            end
            assign edge_evt[gi] = s2_reg & ~s3_reg;
        end
    endgenerate

    logic start_evt, rd_evt, jd_evt, cap_evt, wr_en, rd_en;
    logic [DW-1:0] wr_word;

    assign start_evt = edge_evt[0];
    assign rd_evt    = edge_evt[1];
    // jdclk already lives in the c0 domain, so only an edge detector is needed
    assign jd_evt    = jdclk & ~jd_q_reg;
    // Loss of lock takes precedence over a coincident strobe
    assign cap_evt   = (state_reg == CAPTURE) && locked && jd_evt;
    assign rd_en     = (state_reg == DONE) && rd_evt && !start_evt;

`ifdef ADC_CAP_AVG_EN
    logic [DW-1:0] first_reg;
    logic          half_reg;
    logic [DW:0]   pair_sum;
    assign pair_sum = {1'b0, first_reg} + {1'b0, adc_d};
    assign wr_word  = pair_sum[DW:1];
    assign wr_en    = cap_evt & half_reg;

    always_ff @(posedge c0 or negedge rst) begin
        if (!rst) begin
            first_reg <= '0;
            half_reg  <= 1'b0;
        end else if (((state_reg == IDLE) || (state_reg == DONE)) && start_evt) begin
            half_reg <= 1'b0;
        end else if ((state_reg == CAPTURE) && !locked) begin
            half_reg <= 1'b0;
        end else if (cap_evt) begin
            first_reg <= adc_d;
            half_reg  <= ~half_reg;
        end
    end
`else
    assign wr_word = adc_d;
    assign wr_en   = cap_evt;
`endif

    always_ff @(posedge c0) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_word;
        end
    end

    always_ff @(posedge c0 or negedge rst) begin
        if (!rst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge c0 or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            jd_q_reg   <= 1'b0;
        end else begin
            jd_q_reg <= jdclk;
            case (state_reg)
                IDLE, DONE: begin
                    if (start_evt) begin
                        wr_ptr_reg <= '0;
                        rd_ptr_reg <= '0;
                        cnt_reg    <= '0;
                        err_reg    <= 1'b0;
                        busy_reg   <= 1'b1;
                        done_reg   <= 1'b0;
                        state_reg  <= ARM;
                    end else if (rd_en) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                end
                ARM: begin
                    if (locked) begin
                        state_reg <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (!locked) begin
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (wr_en) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                        cnt_reg    <= cnt_reg + 1'b1;
                        if (wr_ptr_reg == LAST_ADDR) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign err     = err_reg;
    assign cnt     = cnt_reg;
    assign rd_data = rd_data_reg;

endmodule

// File: doc/adc_capture.md
# adc_capture

Sample-capture stage directly downstream of the equivalent-time sampling clock generator. It takes that generator's `jdclk` strobe, which runs in the `c0` domain, and latches the 8-bit ADC output on every strobe rising edge into an on-chip buffer. Once the buffer is full, it hands the record to the MCU through a slow, asynchronous read-strobe interface. It also supervises PLL `locked` and aborts the record if lock is lost.

## Interface
Parameters:
- `DW`, 8: ADC sample width.
- `AW`, 8: buffer address width; depth = 2^AW = 256.

Ports:
- `c0`, in, 1: PLL sample clock; the single clock of the block.
- `rst`, in, 1: reset, asynchronous, active-low.
- `locked`, in, 1: PLL lock indication, synchronous to `c0`.
- `jdclk`, in, 1: sample strobe from the upstream generator, `c0` domain, level signal.
- `adc_d`, in, DW: ADC data, stable around `jdclk` rising edge.
- `start`, in, 1: MCU arm request, asynchronous.
- `rd_stb`, in, 1: MCU read strobe, asynchronous.
- `busy`, out, 1: high in ARM and CAPTURE.
- `done`, out, 1: record complete and readable.
- `err`, out, 1: last record aborted by loss of lock.
- `cnt`, out, AW+1: samples written in the current record.
- `rd_data`, out, DW: current read word.

## Operation
- `start` and `rd_stb` each pass through a 2-flop synchronizer, then a rising-edge detector.
- `jdclk` edge detect: `jd_q` is registered `jdclk`; an event is `jdclk & ~jd_q`. There is no synchronizer, since `jdclk` is already in the `c0` domain.

State machine (IDLE, ARM, CAPTURE, DONE):
- IDLE: a `start` edge clears `wr_ptr`, `rd_ptr`, `cnt` and `err`, then goes to ARM.
- ARM: waits for `locked`=1, then goes to CAPTURE. `jdclk` events are ignored while in ARM.
- CAPTURE: each `jdclk` event writes `adc_d` into `mem[wr_ptr]`, increments `wr_ptr`, and increments `cnt`.
  - The write at address 2^AW−1 moves the block to DONE.
- DONE: each `rd_stb` edge loads `rd_data` from `mem[rd_ptr]` and increments `rd_ptr`.
  - `rd_ptr` wraps modulo 2^AW, so read 257 returns sample 0.
  - A `start` edge in DONE behaves as it does in IDLE: clear, then go to ARM.

Boundary cases:
- `start` edge during ARM or CAPTURE: ignored.
- `rd_stb` edge outside DONE: ignored; `rd_data` holds its value.
- `locked`=0 in CAPTURE: go to IDLE and set `err`=1. Partial data and `cnt` are retained; `done` stays 0.
- `locked`=0 in ARM: remain in ARM.
- `jdclk` event on the same cycle as the ARM→CAPTURE transition: not captured.
- `locked` falling on the same cycle as a `jdclk` event in CAPTURE: abort wins and no write occurs.
- `rst` asserted mid-record: all state is cleared immediately. Memory contents are undefined afterwards.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `err`=0, `cnt`=0, `rd_data`=0, and all pointers 0.
- `start` rising at `c0` edge k: the block enters ARM at edge k+3, and `busy`=1 from k+3.
- ARM→CAPTURE takes 1 cycle after `locked` is sampled high.
- Write latency: a `jdclk` rising edge sampled at edge n is detected at n+1. At n+1, `adc_d` is written and `cnt` updates.
- `done` rises on the cycle after the final write, and `busy` falls on that same cycle.
- Read latency: `rd_stb` edge detected at cycle m gives valid `rd_data` at m+1. The MCU must space strobes at least 4 `c0` cycles apart and sample `rd_data` 5 or more cycles after its strobe.
- `jdclk` events must be at least 2 `c0` cycles apart (high ≥1, low ≥1). Closer events are undefined.

## Configuration
- Macro: `ADC_CAP_AVG_EN`.
- Defined: each stored word is the average of two consecutive CAPTURE events.
  - Sum is DW+1 bits wide; the stored value is `(a+b)>>1`, truncating.
  - The first event of each pair is held in a DW register.
  - `cnt` counts stored words, not events.
  - A record needs 2×2^AW events.
  - Abort on loss of lock discards a half-pair.
- Undefined: one event yields one stored word, as described above.

## Test plan
- Reset, then `start` pulse with `locked`=1, then 256 `jdclk` pulses carrying `adc_d`=i: `done`=1 and `cnt`=256. 256 `rd_stb` pulses return 0..255 in order, and a 257th pulse returns 0.
- `start` with `locked`=0 for 50 cycles, then `locked`=1: the block stays in ARM with `busy`=1 and `cnt`=0. Capture begins only after lock.
- `locked` dropped after 100 samples: state IDLE, `err`=1, `cnt`=100, `done`=0. The next `start` clears `err` and `cnt`.
- `start` edge mid-capture and `rd_stb` edges during CAPTURE: `cnt` and pointers are unaffected, and `rd_data` holds 0.
- `rst` asserted at sample 40, then released, then a full record run: all outputs equal their reset values immediately, and the new record reads back correctly from index 0.
- With `ADC_CAP_AVG_EN` and pair data (10,13),(255,255),…: stored words are 11 and 255. `done` asserts after 512 events.
